// File: rtl/car_pose_tx.sv
// car_pose_tx: 8N1 UART sender for the inter-board pose frame (sync + 6 payload bytes).
// Define POSE_TX_CHECKSUM_EN to append an XOR checksum byte of the payload.
module car_pose_tx #(
  parameter int         CLK_FREQ  = 100_000_000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [9:0] f_x,
  input  logic [9:0] f_y,
  input  logic [9:0] r_x,
  input  logic [9:0] r_y,
  input  logic [1:0] flag,
  input  logic       finish,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
`ifdef POSE_TX_CHECKSUM_EN
  localparam int NBYTES = 8;
`else
  localparam int NBYTES = 7;
`endif
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(NBYTES);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] LAST    = BW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic [47:0]   pay_q, pay_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic [BW-1:0] nxt_idx;
  logic [7:0]    frame_b [2**BW];

`ifdef POSE_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = pay_q[47:40] ^ pay_q[39:32] ^ pay_q[31:24]
              ^ pay_q[23:16] ^ pay_q[15:8]  ^ pay_q[7:0];
`endif

  assign bit_end = (cnt_q == CNT_MAX);
  assign nxt_idx = byte_q + 1'b1;

  // Byte table for the frame, indexed by byte position.
  always_comb begin
    for (int i = 0; i < 2**BW; i++) frame_b[i] = 8'h00;
    frame_b[0] = SYNC_BYTE;
    for (int k = 1; k <= 6; k++) frame_b[k] = pay_q[55-8*k -: 8];
`ifdef POSE_TX_CHECKSUM_EN
    frame_b[7] = csum;
`endif
  end

  // Next-state and output logic for the bit/byte sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    pay_d   = pay_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (send) begin
          state_d = START;
          pay_d   = {5'b0, finish, flag, f_x, f_y, r_x, r_y};
          shift_d = SYNC_BYTE;
          byte_d  = '0;
          cnt_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_q == LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d = START;
            byte_d  = nxt_idx;
            shift_d = frame_b[nxt_idx];
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset to an idle-high line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      pay_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      pay_q   <= pay_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/car_pose_tx.md
CAR_POSE_TX -- requirements
Module: car_pose_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; BIT_CYCLES = CLK_FREQ / BAUD (integer division).
REQ-003 Parameter SYNC_BYTE, default 8'hA5, frame header byte.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 send  input  1  request to transmit one pose frame; sampled every clk.
REQ-007 f_x, f_y, r_x, r_y  input  10 each  own car front/rear pixel coordinates.
REQ-008 flag  input  2  own checkpoint flag; finish  input  1  own finish bit.
REQ-009 tx  output  1  UART line, 8N1, idle high, registered.
REQ-010 busy  output  1  high while a frame is in flight, registered.
REQ-011 done  output  1  one-cycle pulse at frame completion, registered.

Function
REQ-012 The block SHALL be the transmitting end of the inter-board pose link; the peer's receiver supplies the other-car coordinates to the physics engine.
REQ-013 Payload word P[47:0] SHALL be {5'b0, finish, flag, f_x, f_y, r_x, r_y}, split into 6 bytes, P[47:40] first.
REQ-014 The frame SHALL be SYNC_BYTE, then the 6 payload bytes, then an optional checksum byte (REQ-027/028).
REQ-015 The checksum SHALL be the bitwise XOR of the 6 payload bytes; SYNC_BYTE is excluded.
REQ-016 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-017 FSM transitions:
- IDLE->START on an accepted send.
- START->DATA after BIT_CYCLES cycles.
- DATA->STOP after 8 bits.
- STOP->START while bytes remain.
- STOP->IDLE after the last byte.
REQ-018 send SHALL be accepted only when busy is 0; send while busy is 1 SHALL be ignored and not queued.
REQ-019 On the accepting edge, the block SHALL snapshot all pose inputs, set busy to 1 and drive tx to 0 (start bit); input changes during the frame SHALL NOT alter the transmitted bytes.
REQ-020 Each start, data and stop bit SHALL hold for exactly BIT_CYCLES cycles. Data bits go LSB first. The stop bit is 1.
REQ-021 There SHALL be no idle gap between bytes: the next start bit begins on the cycle after the previous stop bit ends.
REQ-022 busy SHALL stay high for exactly NBYTES*10*BIT_CYCLES cycles.
REQ-023 On the edge ending the last stop bit, busy SHALL go to 0 and done SHALL pulse 1 for one cycle; tx remains 1.
REQ-024 A send sampled in the done cycle SHALL be accepted, giving back-to-back frames with no idle bit between them.
REQ-025 The bit-period counter and the byte counter SHALL be wide enough for BIT_CYCLES-1 and NBYTES-1; no wrap SHALL occur within a frame.

Reset
REQ-026 On rst (including mid-frame), the next edge SHALL set tx=1, busy=0, done=0 and the FSM to IDLE, and SHALL clear the counters; an aborted frame SHALL NOT produce done, and send is ignored while rst is high.

Configuration
REQ-027 With macro POSE_TX_CHECKSUM_EN defined, NBYTES SHALL be 8 and the checksum byte SHALL be sent last.
REQ-028 Without POSE_TX_CHECKSUM_EN, NBYTES SHALL be 7, no checksum byte SHALL be sent and no checksum logic SHALL be built.

Verification (CLK_FREQ=1000, BAUD=100, BIT_CYCLES=10)
REQ-029 Reset: hold rst 3 cycles -> tx=1, busy=0, done=0; send during rst is ignored.
REQ-030 Frame: f_x=0x155, f_y=0x2AA, r_x=0x001, r_y=0x3FF, flag=2, finish=1, send 1 cycle.
- Decoded bytes: A5 06 55 6A A0 07 FF 61 (checksum on).
- busy high 800 cycles, then done pulses 1 cycle.
REQ-031 Same stimulus without POSE_TX_CHECKSUM_EN -> bytes A5 06 55 6A A0 07 FF; busy high 700 cycles.
REQ-032 Busy behaviour:
- Pulse send again at cycle 50 and change f_x to 0 at cycle 60 -> frame unchanged, no second frame.
- Send in the done cycle -> second frame's start bit immediately follows the stop bit.
REQ-033 Assert rst at cycle 235 of a frame -> tx=1 and busy=0 at the next edge, no done pulse; a new send then yields a complete, correct frame.
